// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multicycle one-bit-per-clock shift unit.
// Sources and amounts are selected internally and latched on accept.
module shift_unit_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int LUI_AMT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         src_sel,
    input  logic [1:0]         amt_sel,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_imm,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;

    localparam logic [SHAMT_W-1:0] LUI_SH = SHAMT_W'(LUI_AMT);

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] count;
    logic [WIDTH-1:0]   src_val;
    logic [SHAMT_W-1:0] amt_val;
    logic [WIDTH-1:0]   shifted;
    logic               accept;

    // Operand source mux, only consumed at accept.
    always_comb begin
        src_val = '0;
        case (src_sel)
            2'd0:    src_val = in_a;
            2'd1:    src_val = in_b;
            2'd2:    src_val = in_imm;
            default: src_val = '0;
        endcase
    end

    // Shift amount mux; in_b contributes only its low bits.
    always_comb begin
        amt_val = '0;
        case (amt_sel)
            2'd0:    amt_val = in_shamt;
            2'd1:    amt_val = in_b[SHAMT_W-1:0];
            2'd2:    amt_val = LUI_SH;
            default: amt_val = '0;
        endcase
    end

    // Single-bit step of the current result per latched op.
    always_comb begin
        shifted = result;
        case (op_q)
            OP_SLL:  shifted = {result[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, result[WIDTH-1:1]};
            OP_SRA:  shifted = {result[WIDTH-1], result[WIDTH-1:1]};
            default: shifted = {result[0], result[WIDTH-1:1]};
        endcase
    end

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    // Control FSM and datapath registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            result <= '0;
            count  <= '0;
            op_q   <= '0;
        end else if (accept) begin
            result <= src_val;
            count  <= amt_val;
            op_q   <= op;
            state  <= (amt_val != '0) ? S_SHIFT : S_DONE;
        end else begin
            case (state)
                S_SHIFT: begin
                    result <= shifted;
                    count  <= count - 1'b1;
                    if (count == SHAMT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_IDLE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: directed checks of shift_unit_seq.
// Expected values are hand-computed constants.
module tb_shift_unit_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  src_sel;
    logic [1:0]  amt_sel;
    logic [1:0]  op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_imm;
    logic [4:0]  in_shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests;
    int fails;

    shift_unit_seq #(
        .WIDTH(32),
        .SHAMT_W(5),
        .LUI_AMT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .src_sel(src_sel),
        .amt_sel(amt_sel),
        .op(op),
        .in_a(in_a),
        .in_b(in_b),
        .in_imm(in_imm),
        .in_shamt(in_shamt),
        .busy(busy),
        .done(done),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one operation, wait for done, check latency/busy/result.
    // pulse_at > 0 re-asserts start with junk inputs mid-shift.
    // chain = 1 leaves the unit in DONE so the next call re-accepts.
    task automatic run(input string tag, input logic [1:0] s_src,
                       input logic [1:0] s_amt, input logic [1:0] s_op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] sh,
                       input logic [31:0] exp_res, input int exp_cyc,
                       input int pulse_at, input bit chain);
        int cyc;
        int busy_n;
        src_sel  = s_src;
        amt_sel  = s_amt;
        op       = s_op;
        in_a     = a;
        in_b     = b;
        in_imm   = imm;
        in_shamt = sh;
        start    = 1'b1;
        cyc      = 0;
        busy_n   = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_n++;
            if (cyc == pulse_at) begin
                start    = 1'b1;
                src_sel  = 2'd3;
                amt_sel  = 2'd3;
                op       = 2'd0;
                in_a     = 32'hFFFF_FFFF;
                in_shamt = 5'd0;
            end else begin
                start = 1'b0;
            end
        end while (!done && cyc < 200);
        check({tag, " latency"}, cyc, exp_cyc);
        check({tag, " busy cycles"}, busy_n, exp_cyc - 1);
        check({tag, " result"}, result, exp_res);
        if (!chain) begin
            @(posedge clk);
            #1;
            check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
            check({tag, " result held"}, result, exp_res);
        end
    endtask

    initial begin
        int seen_done;
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        src_sel  = 2'd0;
        amt_sel  = 2'd0;
        op       = 2'd0;
        in_a     = 32'h0;
        in_b     = 32'h0;
        in_imm   = 32'h0;
        in_shamt = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run("t1 sll4", 2'd0, 2'd0, 2'd0, 32'h0000_0001, 32'h0, 32'h0,
            5'd4, 32'h0000_0010, 5, 0, 1'b1);
        run("t2 sra0", 2'd1, 2'd1, 2'd2, 32'h0, 32'h8000_0000, 32'h0,
            5'd7, 32'h8000_0000, 1, 0, 1'b0);
        run("t3 sra31", 2'd0, 2'd1, 2'd2, 32'h8000_0000, 32'd31, 32'h0,
            5'd0, 32'hFFFF_FFFF, 32, 0, 1'b0);
        run("t4 lui", 2'd2, 2'd2, 2'd0, 32'h0, 32'h0, 32'h0000_1234,
            5'd0, 32'h1234_0000, 17, 0, 1'b0);
        run("t5 ror1", 2'd0, 2'd0, 2'd3, 32'h0000_0003, 32'h0, 32'h0,
            5'd1, 32'h8000_0001, 2, 0, 1'b0);
        run("t5 ignore", 2'd0, 2'd0, 2'd1, 32'h0000_F000, 32'h0, 32'h0,
            5'd8, 32'h0000_00F0, 9, 3, 1'b0);
        run("srl4", 2'd0, 2'd0, 2'd1, 32'h8000_0000, 32'h0, 32'h0,
            5'd4, 32'h0800_0000, 5, 0, 1'b0);
        run("sra4", 2'd0, 2'd0, 2'd2, 32'h8000_0000, 32'h0, 32'h0,
            5'd4, 32'hF800_0000, 5, 0, 1'b0);
        run("ror4", 2'd0, 2'd0, 2'd3, 32'h0000_0001, 32'h0, 32'h0,
            5'd4, 32'h1000_0000, 5, 0, 1'b0);
        run("zero src", 2'd3, 2'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0,
            5'd2, 32'h0000_0000, 3, 0, 1'b0);

        // Reset in the middle of a 10-bit shift.
        src_sel  = 2'd0;
        amt_sel  = 2'd0;
        op       = 2'd0;
        in_a     = 32'h0000_0001;
        in_shamt = 5'd10;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6 busy before reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6 busy after reset", {31'd0, busy}, 32'd0);
        check("t6 done after reset", {31'd0, done}, 32'd0);
        check("t6 result after reset", result, 32'h0);
        seen_done = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        check("t6 no done after abort", seen_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
